// File: rtl/ddr_pkg.sv
// Shared DDR playfield constants and lane typing, used by the scroller,
// renderer and judge.
package ddr_pkg;

  localparam int unsigned CORDW       = 10;
  localparam int unsigned ARROW_COUNT = 4;
  localparam int unsigned PARK_Y      = 1000;
  localparam int unsigned SPAWN_Y     = 470;
  localparam int unsigned MAX_LANES   = 8;

  typedef logic [$clog2(MAX_LANES)-1:0] lane_idx_t;

endpackage

// File: rtl/arrow_scroller_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 7,5,4,3) that advances only when enabled and
// exposes the low OUTW bits of its next state.
module lfsr8 #(
  parameter logic [7:0]  SEED = 8'hA5,
  parameter int unsigned OUTW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic [OUTW-1:0] next_o
);

  logic [7:0] r_state;
  logic [7:0] w_next;

  always_comb begin
    w_next = {r_state[6:0], r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_state <= SEED;
    else if (en_i) r_state <= w_next;
  end

  assign next_o = w_next[OUTW-1:0];

endmodule

// File: rtl/arrow_scroller.sv
// Per-lane arrow Y generator: scrolls live arrows up once per frame tick,
// spawns from the LFSR pattern, and retires arrows that are hit or missed.
module arrow_scroller
  import ddr_pkg::*;
#(
  parameter int unsigned CORDW        = ddr_pkg::CORDW,
  parameter int unsigned ARROW_COUNT  = ddr_pkg::ARROW_COUNT,
  parameter int unsigned SPAWN_Y      = ddr_pkg::SPAWN_Y,
  parameter int unsigned PARK_Y       = ddr_pkg::PARK_Y,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned SPAWN_PERIOD = 30,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         frame_i,
  input  logic                         run_i,
  input  logic [ARROW_COUNT-1:0]       hit_i,
  output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o,
  output logic [ARROW_COUNT-1:0]       active_o,
  output logic [ARROW_COUNT-1:0]       miss_o
);

  localparam int unsigned CNTW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(SPAWN_PERIOD - 1);
  localparam logic [CORDW-1:0] Y_PARK   = CORDW'(PARK_Y);
  localparam logic [CORDW-1:0] Y_SPAWN  = CORDW'(SPAWN_Y);
  localparam logic [CORDW-1:0] Y_SPEED  = CORDW'(SPEED);

  logic [CNTW-1:0]        r_cnt;
  logic                   w_tick;
  logic                   w_spawn;
  logic [ARROW_COUNT-1:0] w_mask;

  assign w_tick  = frame_i & run_i;
  assign w_spawn = w_tick & (r_cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  lfsr8 #(
    .SEED (LFSR_SEED),
    .OUTW (ARROW_COUNT)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (w_spawn),
    .next_o (w_mask)
  );

  for (genvar k = 0; k < ARROW_COUNT; k++) begin : g_lane
    logic [CORDW-1:0] r_y;
    logic             r_act;
    logic             r_miss;

    // Spawn is only reachable from the inactive branch, so a lane cleared or
    // despawned this cycle cannot respawn until a later spawn tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_act  <= 1'b0;
        r_y    <= Y_PARK;
        r_miss <= 1'b0;
      end else begin
        r_miss <= 1'b0;
        if (r_act) begin
          if (hit_i[k]) begin
            r_act <= 1'b0;
            r_y   <= Y_PARK;
          end else if (w_tick && (r_y <= Y_SPEED)) begin
            r_act  <= 1'b0;
            r_y    <= Y_PARK;
            r_miss <= 1'b1;
          end else if (w_tick) begin
            r_y <= r_y - Y_SPEED;
          end
        end else if (w_spawn && w_mask[k]) begin
          r_act <= 1'b1;
          r_y   <= Y_SPAWN;
        end
      end
    end

    assign arrow_y_o[CORDW*k +: CORDW] = r_y;
    assign active_o[k]                 = r_act;
    assign miss_o[k]                   = r_miss;
  end

endmodule

// File: doc/arrow_scroller.md
# arrow_scroller

Per-lane arrow position generator for the DDR playfield. Once per video frame it scrolls active arrows toward the top of the screen, spawns new arrows from a pseudo-random step pattern, and retires arrows that are hit or missed. Its packed Y-coordinate bus drives the arrow renderer directly. Inactive lanes are parked below the visible area so the renderer needs no enable.

## Interface
Parameters:
- CORDW, 10, coordinate width in bits
- ARROW_COUNT, 4, number of lanes (1..8)
- SPAWN_Y, 470, Y loaded into a lane on spawn
- PARK_Y, 1000, Y driven for inactive lanes (off-screen)
- SPEED, 2, pixels moved up per frame tick (1..SPAWN_Y)
- SPAWN_PERIOD, 30, frame ticks between spawn events (≥1)
- LFSR_SEED, 8'hA5, LFSR reset value (non-zero)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- frame_i  in  1  one-cycle pulse per frame (start of vblank)
- run_i  in  1  1 = game running; 0 = frame ticks ignored
- hit_i  in  ARROW_COUNT  one-cycle per-lane hit pulses from the judge
- arrow_y_o  out  CORDW*ARROW_COUNT  packed Y per lane
- active_o  out  ARROW_COUNT  lane holds a live arrow
- miss_o  out  ARROW_COUNT  one-cycle pulse when an arrow leaves the top unhit

Lane k maps to arrow_y_o[CORDW*(k+1)-1 : CORDW*k] and to bit k of every vector. Lane ARROW_COUNT-1 is the leftmost arrow.

## Operation
- Per-lane state: active bit and a CORDW-bit y register. Inactive lanes always hold y = PARK_Y.
- Tick = frame_i & run_i. Frame counter runs 0..SPAWN_PERIOD-1 on ticks and wraps to 0. The spawn tick is the tick on which counter == SPAWN_PERIOD-1.
- LFSR: 8-bit Fibonacci, fb = b7^b5^b4^b3, next = {lfsr[6:0], fb}. It advances only on spawn ticks. spawn_mask = next[ARROW_COUNT-1:0].
- Per-lane priority within a cycle:
  1. hit_i[k] & active → clear: active=0, y=PARK_Y, no miss. Applies with or without a tick.
  2. Else, on a tick with active and y ≤ SPEED → despawn: active=0, y=PARK_Y, miss_o[k]=1.
  3. Else, on a tick with active → y = y − SPEED. The subtraction cannot underflow because of rule 2.
  4. On a spawn tick, a lane that was inactive at the start of the cycle and has spawn_mask[k]=1 gets active=1, y=SPAWN_Y. A lane cleared or despawned in this cycle does not respawn in the same cycle. spawn_mask bits for occupied lanes are dropped.
- hit_i on an inactive lane is ignored.
- run_i=0: no movement, no spawns, counter and LFSR frozen. Hits are still honoured.

## Timing
- All outputs are registered. An event sampled at edge t appears after edge t (latency 1 cycle).
- miss_o is high for exactly one cycle per despawn.
- Reset (async assert, sync release) sets: active_o=0, every lane y=PARK_Y, miss_o=0, counter=0, lfsr=LFSR_SEED. Reset mid-game discards all arrows immediately.
- frame_i held high for several cycles counts as several ticks. Upstream guarantees a single-cycle pulse.

## Structure
- Shared package ddr_pkg holds CORDW, ARROW_COUNT, PARK_Y, SPAWN_Y, and a lane-index typedef, shared with the renderer and judge.
- Sub-module lfsr8: enable and seed parameter, exposes the next-state value. Lane update is a generate loop in the top module.

## Test plan
- Reset, then idle 100 cycles: arrow_y_o all lanes = 1000, active_o=0, miss_o never high.
- run_i=1, 30 frame pulses: after the 30th, LFSR = 8'h4A, active_o=4'b1010, lanes 1 and 3 at y=470, others at 1000. Counter then back at 0.
- One further frame pulse: lanes 1 and 3 at y=468. 234 pulses after spawn, y=2. Next pulse: lane goes inactive, y=1000, miss_o=4'b1010 for one cycle.
- Lane 1 at y=2, with hit_i[1] and frame_i in the same cycle: lane 1 inactive, y=1000, miss_o[1] stays 0. Lane 3 misses normally.
- run_i=0, 50 frame pulses: positions, counter and LFSR unchanged. hit_i[3] still clears lane 3 within 1 cycle.
- Assert rst_i asynchronously while arrows are live: outputs return to reset values before the next clk_i edge. After release, the first spawn again occurs on the 30th tick with mask 4'b1010.
